// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage plus the MEM/WB pipeline register.
// A load or store waits WAIT_STATES extra cycles (stalling upstream) before
// it completes; non-memory ops pass straight through in one edge.
module mem_stage #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_result_in,
  input  logic [7:0] writedata_in,
  input  logic [4:0] rd_in,
  input  logic       memread_in,
  input  logic       memwrite_in,
  input  logic       memtoreg_in,
  input  logic       regwrite_in,
  output logic       stall,
  output logic [7:0] readdata_out,
  output logic [7:0] alu_result_out,
  output logic [4:0] rd_out,
  output logic       Memtoreg,
  output logic       Regwrite
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [2:0] CNT_START = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  state_t            next_state;
  logic [2:0]        cnt;
  logic [2:0]        next_cnt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic              mem_req;
  logic              is_load;
  logic              complete;
  logic              stall_raw;

  // Upper address bits are dropped, so addresses alias modulo DEPTH.
  assign addr    = alu_result_in[ADDR_W-1:0];
  assign mem_req = memread_in | memwrite_in;
  // A request with both strobes set behaves as a store.
  assign is_load = memread_in & ~memwrite_in;
  // Stall is forced low while reset is held so upstream is never frozen by a dead stage.
  assign stall   = stall_raw & reset;

  // State register and wait counter; reset aborts any access in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Decide whether this edge completes the current op or inserts a bubble.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall_raw  = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && (WAIT_STATES != 0)) begin
          stall_raw  = 1'b1;
          next_state = WAIT;
          next_cnt   = CNT_START;
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        if (cnt != 3'd0) begin
          stall_raw = 1'b1;
          next_cnt  = cnt - 3'd1;
        end else begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 3'd0;
      end
    endcase
  end

  // Store commits only on the completion edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (complete && memwrite_in) begin
      mem[addr] <= writedata_in;
    end
  end

  // MEM/WB register: load the write-back fields on completion, otherwise a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_out   <= 8'h00;
      alu_result_out <= 8'h00;
      rd_out         <= 5'd0;
      Memtoreg       <= 1'b0;
      Regwrite       <= 1'b0;
    end else if (complete) begin
      readdata_out   <= is_load ? mem[addr] : 8'h00;
      alu_result_out <= alu_result_in;
      rd_out         <= rd_in;
      Memtoreg       <= memtoreg_in;
      Regwrite       <= regwrite_in;
    end else begin
      readdata_out   <= 8'h00;
      alu_result_out <= 8'h00;
      rd_out         <= 5'd0;
      Memtoreg       <= 1'b0;
      Regwrite       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: four mem_stage instances with WAIT_STATES 0..3, each checked
// against a simple byte-array memory model.
module tb_mem_stage;

  logic       clk;
  logic       reset;
  logic [7:0] alu_in   [4];
  logic [7:0] wdata_in [4];
  logic [4:0] rd_in    [4];
  logic       mread_in [4];
  logic       mwrite_in[4];
  logic       mtr_in   [4];
  logic       rw_in    [4];
  logic       stall_o  [4];
  logic [7:0] rdata_o  [4];
  logic [7:0] alu_o    [4];
  logic [4:0] rd_o     [4];
  logic       mtr_o    [4];
  logic       rw_o     [4];

  logic [7:0] model_mem   [4][32];
  bit         model_valid [4][32];

  int total = 0;
  int bad   = 0;

  // Instance g has WAIT_STATES = g.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_stage #(.DEPTH(32), .WAIT_STATES(g)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .alu_result_in (alu_in[g]),
      .writedata_in  (wdata_in[g]),
      .rd_in         (rd_in[g]),
      .memread_in    (mread_in[g]),
      .memwrite_in   (mwrite_in[g]),
      .memtoreg_in   (mtr_in[g]),
      .regwrite_in   (rw_in[g]),
      .stall         (stall_o[g]),
      .readdata_out  (rdata_o[g]),
      .alu_result_out(alu_o[g]),
      .rd_out        (rd_o[g]),
      .Memtoreg      (mtr_o[g]),
      .Regwrite      (rw_o[g])
    );
  end

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs(input int idx);
    alu_in[idx]    = 8'h00;
    wdata_in[idx]  = 8'h00;
    rd_in[idx]     = 5'd0;
    mread_in[idx]  = 1'b0;
    mwrite_in[idx] = 1'b0;
    mtr_in[idx]    = 1'b0;
    rw_in[idx]     = 1'b0;
  endtask

  // Present one op, ride out its stall cycles, and capture the MEM/WB result.
  // Called just after a rising edge; returns just after the completion edge.
  task automatic run_op(input int idx, input bit rd_en, input bit wr_en,
                        input logic [7:0] alu, input logic [7:0] wdata,
                        input logic [4:0] rd, input bit mtr, input bit rw,
                        output int n_stall, output bit bubble_bad,
                        output logic [7:0] o_rdata, output logic [7:0] o_alu,
                        output logic [4:0] o_rd, output logic o_mtr, output logic o_rw);
    alu_in[idx]    = alu;
    wdata_in[idx]  = wdata;
    rd_in[idx]     = rd;
    mread_in[idx]  = rd_en;
    mwrite_in[idx] = wr_en;
    mtr_in[idx]    = mtr;
    rw_in[idx]     = rw;
    n_stall    = 0;
    bubble_bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (stall_o[idx] !== 1'b1) break;
      n_stall++;
      @(posedge clk);
      #1;
      if (rw_o[idx] !== 1'b0 || mtr_o[idx] !== 1'b0 || rd_o[idx] !== 5'd0 ||
          alu_o[idx] !== 8'h00 || rdata_o[idx] !== 8'h00) bubble_bad = 1'b1;
    end
    @(posedge clk);
    #1;
    o_rdata = rdata_o[idx];
    o_alu   = alu_o[idx];
    o_rd    = rd_o[idx];
    o_mtr   = mtr_o[idx];
    o_rw    = rw_o[idx];
    clear_inputs(idx);
  endtask

  // Asynchronous reset mid-cycle forces every output to zero at once.
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      alu_in[i]    = 8'h80 | 8'($urandom);
      rd_in[i]     = 5'd1 | 5'($urandom);
      rw_in[i]     = 1'b1;
      mtr_in[i]    = 1'b1;
      mread_in[i]  = 1'b0;
      mwrite_in[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      alu_in[i]   = 8'($urandom);
      rd_in[i]    = 5'($urandom);
      mread_in[i] = 1'b1;
    end
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (stall_o[i] !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall[%0d]: got %b want 0", i, stall_o[i]); end
      total++;
      if (rw_o[i] !== 1'b0 || mtr_o[i] !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_ctrl[%0d]: got rw=%b mtr=%b want 0 0", i, rw_o[i], mtr_o[i]);
      end
      total++;
      if (alu_o[i] !== 8'h00 || rd_o[i] !== 5'd0 || rdata_o[i] !== 8'h00) begin
        bad++; $display("[TB] FAIL reset_data[%0d]: got alu=%h rd=%0d rdata=%h want 0", i, alu_o[i], rd_o[i], rdata_o[i]);
      end
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) clear_inputs(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (stall_o[i] !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_stall[%0d]: got %b want 0", i, stall_o[i]); end
    end
  endtask

  // Non-memory op on WAIT_STATES=1: one edge, no stall.
  task automatic test_pass_through();
    int n; bit bb; logic [7:0] rdv, alv; logic [4:0] rdo; logic mt, rw;
    run_op(1, 0, 0, 8'h3C, 8'h00, 5'd7, 0, 1, n, bb, rdv, alv, rdo, mt, rw);
    total++; if (n !== 0) begin bad++; $display("[TB] FAIL pass_stall: got %0d cycles want 0", n); end
    total++; if (alv !== 8'h3C) begin bad++; $display("[TB] FAIL pass_alu: got %h want 3c", alv); end
    total++; if (rdo !== 5'd7) begin bad++; $display("[TB] FAIL pass_rd: got %0d want 7", rdo); end
    total++; if (rw !== 1'b1 || mt !== 1'b0) begin bad++; $display("[TB] FAIL pass_ctrl: got rw=%b mtr=%b want 1 0", rw, mt); end
    total++; if (rdv !== 8'h00) begin bad++; $display("[TB] FAIL pass_rdata: got %h want 00", rdv); end
  endtask

  // Store then load on WAIT_STATES=2.
  task automatic test_store_load();
    int n; bit bb; logic [7:0] rdv, alv; logic [4:0] rdo; logic mt, rw;
    run_op(2, 0, 1, 8'h05, 8'hA5, 5'd9, 0, 0, n, bb, rdv, alv, rdo, mt, rw);
    model_mem[2][5] = 8'hA5; model_valid[2][5] = 1'b1;
    total++; if (n !== 2) begin bad++; $display("[TB] FAIL store_stall: got %0d cycles want 2", n); end
    total++; if (bb !== 1'b0) begin bad++; $display("[TB] FAIL store_bubble: got %b want 0", bb); end
    run_op(2, 1, 0, 8'h05, 8'h00, 5'd3, 1, 1, n, bb, rdv, alv, rdo, mt, rw);
    total++; if (n !== 2) begin bad++; $display("[TB] FAIL load_stall: got %0d cycles want 2", n); end
    total++; if (rdv !== 8'hA5) begin bad++; $display("[TB] FAIL load_rdata: got %h want a5", rdv); end
    total++; if (rdo !== 5'd3 || mt !== 1'b1 || rw !== 1'b1) begin
      bad++; $display("[TB] FAIL load_wb: got rd=%0d mtr=%b rw=%b want 3 1 1", rdo, mt, rw);
    end
  endtask

  // Upper address bits are ignored: 0x25 and 0x05 hit the same byte.
  task automatic test_alias();
    int n; bit bb; logic [7:0] rdv, alv; logic [4:0] rdo; logic mt, rw;
    run_op(1, 0, 1, 8'h25, 8'h11, 5'd0, 0, 0, n, bb, rdv, alv, rdo, mt, rw);
    model_mem[1][5] = 8'h11; model_valid[1][5] = 1'b1;
    run_op(1, 1, 0, 8'h05, 8'h00, 5'd4, 1, 1, n, bb, rdv, alv, rdo, mt, rw);
    total++; if (rdv !== 8'h11) begin bad++; $display("[TB] FAIL alias_rdata: got %h want 11", rdv); end
  endtask

  // Reset during the second stall cycle of a store must abort it.
  task automatic test_reset_mid_access();
    int n; bit bb; logic [7:0] rdv, alv; logic [4:0] rdo; logic mt, rw;
    run_op(3, 0, 1, 8'h02, 8'h77, 5'd0, 0, 0, n, bb, rdv, alv, rdo, mt, rw);
    model_mem[3][2] = 8'h77; model_valid[3][2] = 1'b1;
    alu_in[3] = 8'h02; wdata_in[3] = 8'hEE; mwrite_in[3] = 1'b1;
    @(posedge clk);
    #1;
    total++; if (stall_o[3] !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_wait: got stall=%b want 1", stall_o[3]); end
    #2 reset = 1'b0;
    #1;
    total++; if (stall_o[3] !== 1'b0) begin bad++; $display("[TB] FAIL abort_stall: got %b want 0", stall_o[3]); end
    #1 reset = 1'b1;
    clear_inputs(3);
    @(posedge clk);
    #1;
    run_op(3, 1, 0, 8'h02, 8'h00, 5'd5, 1, 1, n, bb, rdv, alv, rdo, mt, rw);
    total++; if (n !== 3) begin bad++; $display("[TB] FAIL abort_load_stall: got %0d cycles want 3", n); end
    total++; if (rdv !== 8'h77) begin bad++; $display("[TB] FAIL abort_rdata: got %h want 77", rdv); end
  endtask

  // WAIT_STATES=0: back-to-back store and load, never stalling.
  task automatic test_zero_wait();
    int n; bit bb; logic [7:0] rdv, alv; logic [4:0] rdo; logic mt, rw;
    run_op(0, 0, 1, 8'h09, 8'h42, 5'd0, 0, 0, n, bb, rdv, alv, rdo, mt, rw);
    model_mem[0][9] = 8'h42; model_valid[0][9] = 1'b1;
    total++; if (n !== 0) begin bad++; $display("[TB] FAIL zw_store_stall: got %0d cycles want 0", n); end
    run_op(0, 1, 0, 8'h09, 8'h00, 5'd2, 1, 1, n, bb, rdv, alv, rdo, mt, rw);
    total++; if (n !== 0) begin bad++; $display("[TB] FAIL zw_load_stall: got %0d cycles want 0", n); end
    total++; if (rdv !== 8'h42) begin bad++; $display("[TB] FAIL zw_rdata: got %h want 42", rdv); end
  endtask

  // Random back-to-back ops on every instance against the byte-array model.
  task automatic test_back_to_back();
    for (int idx = 0; idx < 4; idx++) begin
      for (int k = 0; k < 25; k++) begin
        int n, kind, slot, want_stall; bit bb, r, w, check_rd;
        logic [7:0] a, wd, rdv, alv, exp_rd; logic [4:0] rdi, rdo; logic mt, rw, mti, rwi;
        kind = $urandom_range(0, 3);
        r    = (kind == 2) || (kind == 3);
        w    = (kind == 1) || (kind == 3);
        a    = 8'($urandom_range(0, 7)) | (8'($urandom) & 8'hE0);
        wd   = 8'($urandom);
        rdi  = 5'($urandom);
        mti  = 1'($urandom);
        rwi  = 1'($urandom);
        slot = int'(a) % 32;
        want_stall = (r || w) ? idx : 0;
        exp_rd   = 8'h00;
        check_rd = 1'b1;
        if (r && !w) begin
          if (model_valid[idx][slot]) exp_rd = model_mem[idx][slot];
          else check_rd = 1'b0;
        end
        run_op(idx, r, w, a, wd, rdi, mti, rwi, n, bb, rdv, alv, rdo, mt, rw);
        if (w) begin model_mem[idx][slot] = wd; model_valid[idx][slot] = 1'b1; end
        total++;
        if (n !== want_stall || bb !== 1'b0) begin
          bad++; $display("[TB] FAIL rnd_stall[%0d]: got %0d cycles bubble_err=%b want %0d 0", idx, n, bb, want_stall);
        end
        total++;
        if (alv !== a || rdo !== rdi || mt !== mti || rw !== rwi) begin
          bad++; $display("[TB] FAIL rnd_wb[%0d]: got alu=%h rd=%0d mtr=%b rw=%b want %h %0d %b %b",
                          idx, alv, rdo, mt, rw, a, rdi, mti, rwi);
        end
        if (check_rd) begin
          total++;
          if (rdv !== exp_rd) begin bad++; $display("[TB] FAIL rnd_rdata[%0d]: got %h want %h", idx, rdv, exp_rd); end
        end
      end
    end
  endtask

  // Test sequence.
  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clear_inputs(i);
      for (int j = 0; j < 32; j++) begin model_mem[i][j] = 8'h00; model_valid[i][j] = 1'b0; end
    end
    #12 reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_pass_through();
    test_store_load();
    test_alias();
    test_reset_mid_access();
    test_zero_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage and MEM/WB pipeline register of the 8-bit pipelined processor. Consumes the request fields produced by the EX/MEM register, performs the data-memory read or write with a configurable number of wait states, and stalls upstream stages while an access is in progress. On completion it registers the write-back fields for the register file.

## Interface
- DEPTH, 32, data-memory size in bytes; power of two, 2..256; ADDR_W = log2(DEPTH)
- WAIT_STATES, 1, extra cycles per memory access; 0..7
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- alu_result_in  input  8  ALU result from EX/MEM; memory address (low ADDR_W bits) or pass-through value
- writedata_in  input  8  store data from EX/MEM
- rd_in  input  5  destination register from EX/MEM
- memread_in  input  1  load request
- memwrite_in  input  1  store request
- memtoreg_in  input  1  write-back select passed to WB
- regwrite_in  input  1  register-write enable passed to WB
- stall  output  1  combinational; high = upstream must hold its outputs stable
- readdata_out  output  8  loaded byte, registered
- alu_result_out  output  8  registered ALU result
- rd_out  output  5  registered destination register
- Memtoreg  output  1  registered write-back select
- Regwrite  output  1  registered register-write enable

## Operation
- mem_req = memread_in | memwrite_in. Address = alu_result_in[ADDR_W-1:0]; upper bits ignored (addresses alias modulo DEPTH).
- Both memread_in and memwrite_in high: treated as a store; readdata_out loads 0.
- FSM states: IDLE, WAIT. 3-bit counter cnt.
- IDLE, no mem_req: stall=0; at the edge, MEM/WB registers load the inputs; readdata_out loads 0.
- IDLE, mem_req, WAIT_STATES=0: same as above, plus the access completes at this edge. A store writes writedata_in to mem[addr]. A load sets readdata_out = mem[addr], reflecting memory contents before this edge.
- IDLE, mem_req, WAIT_STATES>0: stall=1. At the edge, go to WAIT with cnt=WAIT_STATES-1 and load a bubble.
- WAIT: stall = (cnt!=0).
  - cnt!=0: at the edge, decrement cnt and load a bubble.
  - cnt==0: at the edge, complete the access using the current inputs, load the MEM/WB registers as in IDLE, and return to IDLE.
- Bubble: Regwrite=0, Memtoreg=0, rd_out=0, alu_result_out=0, readdata_out=0.
- Upstream holds all inputs constant while stall=1. Input changes during a stall are not defined behaviour and are not checked.
- Memory array contents are not affected by reset.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, and all registered outputs are 0. stall is combinationally low in IDLE while reset is asserted.
- Reset asserted in WAIT: the pending access is aborted and a store is not committed. After release, the block is in IDLE.
- Latency, non-memory op: 1 edge; stall never asserts.
- Latency, memory op: WAIT_STATES+1 edges from input presentation to valid MEM/WB outputs. stall is high for exactly WAIT_STATES consecutive cycles.
- Store commit: occurs only at the completion edge, and only once per request.
- Back-to-back memory ops: the next request can be presented in the cycle immediately after completion. It starts a new count from IDLE with no idle gap.
- Load after store to the same address, in consecutive requests: the load returns the stored byte.

## Test plan
- Reset: drive reset=0 mid-cycle with arbitrary inputs. Required: all outputs 0 immediately (asynchronously) and stall=0. After release, state is IDLE.
- Pass-through, WAIT_STATES=1: alu_result_in=0x3C, rd_in=7, regwrite_in=1, memtoreg_in=0. Required: one edge later alu_result_out=0x3C, rd_out=7, Regwrite=1, readdata_out=0; stall stays 0.
- Store then load, WAIT_STATES=2: store 0xA5 to address 0x05; stall is high for 2 cycles and Regwrite=0 during the stall. Then load from 0x05 with rd_in=3, memtoreg_in=1, regwrite_in=1. Required: after 3 edges readdata_out=0xA5, rd_out=3, Memtoreg=1, Regwrite=1.
- Aliasing, DEPTH=32: store 0x11 to address 0x25, then load from address 0x05. Required: readdata_out=0x11.
- Reset mid-access, WAIT_STATES=3: mem[0x02] holds 0x77. Start a store of 0xEE to 0x02, pulse reset low during the second stall cycle, then load from 0x02. Required: readdata_out=0x77 (store aborted).
- Zero wait states: WAIT_STATES=0, back-to-back store of 0x42 to 0x09, then load from 0x09. Required: stall never asserts, and the load yields 0x42 one edge after it is presented.
